ccff_multi_chain_loader: RTL and testbench

- Single-clock programming controller for a fabric split into NUM_CHAINS parallel configuration chains.
- Accepts bitstream words over a valid/ready stream and performs the preset pulse.
- Paces the shift enables and serialises words onto all chain heads in lockstep.
- Tracks tail parity for readback checks and releases IO isolation only after a complete load; also supports a clear (shift-zeros) mode.

---
 rtl/ccff_multi_chain_loader.sv | 204 ++++++++++++++++++++
 tb/tb_ccff_multi_chain_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_multi_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_multi_chain_loader
//
// Programming controller for a fabric whose configuration flops are split
// into NUM_CHAINS equal-length chains that shift in lockstep. An operation
// pulses the fabric preset and then either streams bitstream words onto the
// chain heads (load) or shifts zeros through every chain (clear). IO
// isolation is released only once a full CHAIN_LEN shifts have completed.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start, mode       start request (IDLE/DONE only); mode 0 = load, 1 = clear
//   abort             return to IDLE on the next edge from any state
//   s_data/s_valid/s_ready   bitstream word stream (accepted in FETCH only)
//   pReset            fabric preset pulse, PRESET_CYC cycles long
//   ccff_shift_en     one-cycle shift strobe, every CLK_DIV cycles
//   ccff_head         chain head bits (bit i feeds chain i)
//   ccff_tail         chain tail bits, folded into tail_parity on strobes
//   IO_ISOL_N         0 = fabric IO isolated; 1 only while DONE
//   busy, done        operation in progress / completed (sticky)
//   tail_parity       running XOR of all tail bits seen on strobes
//   shift_count       strobes issued during the current operation
// ---------------------------------------------------------------------------
module ccff_multi_chain_loader #(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 1024,
    parameter int WORD_W     = 32,
    parameter int CLK_DIV    = 2,
    parameter int PRESET_CYC = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             mode,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic                             pReset,
    output logic                             ccff_shift_en,
    output logic [NUM_CHAINS-1:0]            ccff_head,
    input  logic [NUM_CHAINS-1:0]            ccff_tail,
    output logic                             IO_ISOL_N,
    output logic                             busy,
    output logic                             done,
    output logic                             tail_parity,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   shift_count
);

    localparam int SPW   = WORD_W / NUM_CHAINS;
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int SUB_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PRE_W = (PRESET_CYC > 1) ? $clog2(PRESET_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SPW - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESET_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESET = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_SHIFT  = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // XOR-reduce of the chain tails, folded into the running parity
    function automatic logic parity_f(input logic [NUM_CHAINS-1:0] bits);
        return ^bits;
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [PRE_W-1:0]  pre_cnt_r;
    logic [DIV_W-1:0]  div_r;
    logic [SUB_W-1:0]  sub_r;
    logic [WORD_W-1:0] word_r;
    logic              mode_r;
    logic [CNT_W-1:0]  shift_count_r;
    logic              tail_parity_r;

    logic pacing_s;
    logic strobe_s;
    logic last_shift_s;
    logic last_sub_s;
    logic pre_last_s;
    logic start_ok_s;

    assign pacing_s     = (state_r == ST_SHIFT) || (state_r == ST_CLEAR);
    assign strobe_s     = pacing_s && (div_r == DIV_LAST);
    assign last_shift_s = (shift_count_r == CNT_LAST);
    assign last_sub_s   = (sub_r == SUB_LAST);
    assign pre_last_s   = (pre_cnt_r == PRE_LAST);
    assign start_ok_s   = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Next-state selection; abort overrides everything except reset
    always_comb begin
        state_nx_s = state_r;
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) state_nx_s = ST_PRESET;
                    else       state_nx_s = state_r;
                end
                ST_PRESET: begin
                    if (pre_last_s) state_nx_s = mode_r ? ST_CLEAR : ST_FETCH;
                    else            state_nx_s = ST_PRESET;
                end
                ST_FETCH: begin
                    if (s_valid) state_nx_s = ST_SHIFT;
                    else         state_nx_s = ST_FETCH;
                end
                ST_SHIFT: begin
                    // The final strobe wins over the word boundary, so leftover
                    // bits of the last word are dropped and no word is requested.
                    if (strobe_s && last_shift_s)    state_nx_s = ST_DONE;
                    else if (strobe_s && last_sub_s) state_nx_s = ST_FETCH;
                    else                             state_nx_s = ST_SHIFT;
                end
                ST_CLEAR: begin
                    if (strobe_s && last_shift_s) state_nx_s = ST_DONE;
                    else                          state_nx_s = ST_CLEAR;
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nx_s;
    end

    // Preset pulse length counter, idle at zero outside PRESET
    always_ff @(posedge clk) begin
        if (reset)                      pre_cnt_r <= {PRE_W{1'b0}};
        else if (state_r == ST_PRESET)  pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        else                            pre_cnt_r <= {PRE_W{1'b0}};
    end

    // Shift pacing divider; restarts at zero on entry to SHIFT/CLEAR
    always_ff @(posedge clk) begin
        if (reset)         div_r <= {DIV_W{1'b0}};
        else if (strobe_s) div_r <= {DIV_W{1'b0}};
        else if (pacing_s) div_r <= div_r + DIV_W'(1);
        else               div_r <= {DIV_W{1'b0}};
    end

    // Word holding register: the head slice is always the low NUM_CHAINS bits,
    // so each strobe shifts the next slice down instead of muxing on sub_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= {WORD_W{1'b0}};
            sub_r  <= {SUB_W{1'b0}};
        end else if ((state_r == ST_FETCH) && s_valid) begin
            word_r <= s_data;
            sub_r  <= {SUB_W{1'b0}};
        end else if (strobe_s) begin
            word_r <= word_r >> NUM_CHAINS;
            sub_r  <= sub_r + SUB_W'(1);
        end else begin
            word_r <= word_r;
            sub_r  <= sub_r;
        end
    end

    // Operation bookkeeping: mode latch, shift count and tail parity.
    // Abort leaves count and parity untouched so they can be inspected.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r        <= 1'b0;
            shift_count_r <= {CNT_W{1'b0}};
            tail_parity_r <= 1'b0;
        end else if (start_ok_s) begin
            mode_r        <= mode;
            shift_count_r <= {CNT_W{1'b0}};
            tail_parity_r <= 1'b0;
        end else if (strobe_s) begin
            mode_r        <= mode_r;
            shift_count_r <= shift_count_r + CNT_W'(1);
            tail_parity_r <= tail_parity_r ^ parity_f(ccff_tail);
        end else begin
            mode_r        <= mode_r;
            shift_count_r <= shift_count_r;
            tail_parity_r <= tail_parity_r;
        end
    end

    assign s_ready       = (state_r == ST_FETCH);
    assign pReset        = (state_r == ST_PRESET);
    assign ccff_shift_en = strobe_s;
    assign ccff_head     = (state_r == ST_SHIFT) ? word_r[NUM_CHAINS-1:0] : {NUM_CHAINS{1'b0}};
    // Isolation is re-applied in the very cycle a new operation is requested.
    assign IO_ISOL_N     = (state_r == ST_DONE) && !start;
    assign busy          = (state_r != ST_IDLE) && (state_r != ST_DONE);
    assign done          = (state_r == ST_DONE);
    assign tail_parity   = tail_parity_r;
    assign shift_count   = shift_count_r;

endmodule

// File: tb/tb_ccff_multi_chain_loader.sv
module tb_ccff_multi_chain_loader;

    localparam int NC        = 4;
    localparam int WW        = 32;
    localparam int SPW       = WW / NC;
    localparam int STALL_CYC = 50;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic          abort;
    logic [WW-1:0] s_data;
    logic          s_valid;
    logic [NC-1:0] tail;
    logic [NC-1:0] tail_fixed;
    logic          tail_rand;

    // per-instance outputs: 0 = default, 1 = short chain / CLK_DIV 1, 2 = odd length
    logic [2:0]  o_ready, o_preset, o_en, o_iso, o_busy, o_done, o_par;
    logic [11:0] o_head;
    logic [10:0] a_cnt;
    logic [3:0]  b_cnt;
    logic [9:0]  c_cnt;

    int sel;
    logic          cur_ready, cur_preset, cur_en, cur_iso, cur_busy, cur_done, cur_par;
    logic [NC-1:0] cur_head;
    logic [10:0]   cur_cnt;

    int cl_cur;
    int div_cur;
    logic [31:0] sent[$];
    int words_acc;
    int op_strobes;
    int op_cyc;
    logic par_m;
    logic m_mode;
    int n_tests;
    int n_fail;

    ccff_multi_chain_loader dut_a (
        .clk(clk), .reset(reset), .start(start && (sel == 0)), .mode(mode), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(o_ready[0]), .pReset(o_preset[0]),
        .ccff_shift_en(o_en[0]), .ccff_head(o_head[3:0]), .ccff_tail(tail),
        .IO_ISOL_N(o_iso[0]), .busy(o_busy[0]), .done(o_done[0]),
        .tail_parity(o_par[0]), .shift_count(a_cnt)
    );

    ccff_multi_chain_loader #(.CHAIN_LEN(10), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(start && (sel == 1)), .mode(mode), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(o_ready[1]), .pReset(o_preset[1]),
        .ccff_shift_en(o_en[1]), .ccff_head(o_head[7:4]), .ccff_tail(tail),
        .IO_ISOL_N(o_iso[1]), .busy(o_busy[1]), .done(o_done[1]),
        .tail_parity(o_par[1]), .shift_count(b_cnt)
    );

    ccff_multi_chain_loader #(.CHAIN_LEN(1023)) dut_c (
        .clk(clk), .reset(reset), .start(start && (sel == 2)), .mode(mode), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(o_ready[2]), .pReset(o_preset[2]),
        .ccff_shift_en(o_en[2]), .ccff_head(o_head[11:8]), .ccff_tail(tail),
        .IO_ISOL_N(o_iso[2]), .busy(o_busy[2]), .done(o_done[2]),
        .tail_parity(o_par[2]), .shift_count(c_cnt)
    );

    always_comb begin
        cur_ready  = o_ready[sel];
        cur_preset = o_preset[sel];
        cur_en     = o_en[sel];
        cur_iso    = o_iso[sel];
        cur_busy   = o_busy[sel];
        cur_done   = o_done[sel];
        cur_par    = o_par[sel];
        cur_head   = o_head[sel*NC +: NC];
        case (sel)
            1:       cur_cnt = 11'(b_cnt);
            2:       cur_cnt = 11'(c_cnt);
            default: cur_cnt = a_cnt;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tail bits change shortly after each edge so they are stable across a strobe cycle
    initial begin
        tail = 4'h0;
        forever begin
            @(posedge clk);
            #2;
            tail = tail_rand ? 4'($urandom) : tail_fixed;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_s_ready"}, cur_ready, 0);
        chk({pfx, "_pReset"}, cur_preset, 0);
        chk({pfx, "_shift_en"}, cur_en, 0);
        chk({pfx, "_head"}, cur_head, 0);
        chk({pfx, "_iso_n"}, cur_iso, 0);
        chk({pfx, "_busy"}, cur_busy, 0);
        chk({pfx, "_done"}, cur_done, 0);
        chk({pfx, "_parity"}, cur_par, 0);
        chk({pfx, "_count"}, cur_cnt, 0);
    endtask

    task automatic begin_op(input logic m, input int s, input int cl, input int dv);
        sel        = s;
        cl_cur     = cl;
        div_cur    = dv;
        m_mode     = m;
        sent.delete();
        words_acc  = 0;
        op_strobes = 0;
        op_cyc     = 0;
        par_m      = 1'b0;
    endtask

    // Requests an operation and measures the preset pulse; poke re-asserts start mid-preset
    task automatic do_start(input bit from_done, input bit poke);
        int pcyc;
        bit left;
        pcyc  = 0;
        left  = 0;
        mode  = m_mode;
        start = 1'b1;
        @(negedge clk);
        if (from_done) chk("iso_drops_with_start", cur_iso, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m_mode;
        for (int i = 0; i < 20 && !left; i++) begin
            start = poke && (i == 1);
            @(negedge clk);
            if (cur_preset) pcyc++;
            if (i == 0) begin
                chk("count_cleared_on_start", cur_cnt, 0);
                chk("parity_cleared_on_start", cur_par, 0);
                chk("done_cleared_on_start", cur_done, 0);
                chk("busy_in_preset", cur_busy, 1);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!cur_preset) left = 1;
        end
        chk("preset_len", pcyc, 4);
    endtask

    // Services the stream and checks every strobe against the flat bitstream model
    task automatic drive_op(input int limit, input int stall_word, input int budget);
        int stall_left;
        int last_cyc;
        int k;
        bit hs;
        bit fin;
        logic [NC-1:0] prev_head;
        logic [NC-1:0] stall_head;
        logic [NC-1:0] exp_head;
        logic [10:0]   stall_cnt;
        logic [31:0]   w;
        stall_left = STALL_CYC;
        last_cyc   = -1;
        fin        = 0;
        prev_head  = cur_head;
        stall_head = 4'h0;
        stall_cnt  = 11'd0;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            s_valid = !((words_acc == stall_word) && (stall_left > 0));
            s_data  = $urandom;
            @(negedge clk);
            hs = s_valid && cur_ready;
            if ((words_acc == stall_word) && (stall_left > 0) && cur_ready) begin
                if (stall_left == STALL_CYC) begin
                    stall_head = cur_head;
                    stall_cnt  = cur_cnt;
                end else begin
                    chk("stall_head_stable", cur_head, stall_head);
                    chk("stall_count_frozen", cur_cnt, stall_cnt);
                end
                chk("stall_no_strobe", cur_en, 0);
                stall_left--;
            end
            if (cur_en) begin
                k = op_strobes;
                if (m_mode) begin
                    exp_head = 4'h0;
                end else if (k / SPW < sent.size()) begin
                    w        = sent[k / SPW];
                    exp_head = w[(k % SPW) * NC +: NC];
                end else begin
                    exp_head = 4'bxxxx;
                end
                chk("head_at_strobe", cur_head, exp_head);
                if (div_cur > 1) chk("head_held_over_period", prev_head, cur_head);
                if ((last_cyc >= 0) && (m_mode || (k % SPW != 0)))
                    chk("strobe_spacing", op_cyc - last_cyc, div_cur);
                last_cyc = op_cyc;
                par_m    = par_m ^ (^tail);
                op_strobes++;
            end
            prev_head = cur_head;
            @(posedge clk);
            if (hs) begin
                sent.push_back(s_data);
                words_acc++;
            end
            op_cyc++;
            #1;
            if (cur_done || ((limit > 0) && (op_strobes >= limit))) fin = 1;
        end
        s_valid = 1'b0;
        chk("op_finished_within_budget", fin, 1);
    endtask

    task automatic chk_op_done(input int exp_words, input logic exp_par);
        @(negedge clk);
        chk("strobes_total", op_strobes, cl_cur);
        chk("words_accepted", words_acc, exp_words);
        chk("shift_count_final", cur_cnt, cl_cur);
        chk("done_set", cur_done, 1);
        chk("iso_released", cur_iso, 1);
        chk("busy_clear", cur_busy, 0);
        chk("head_zero_in_done", cur_head, 0);
        chk("tail_parity", cur_par, exp_par);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_no_ready_after_done();
        s_valid = 1'b1;
        repeat (4) begin
            s_data = $urandom;
            @(negedge clk);
            chk("no_ready_after_done", cur_ready, 0);
            chk("done_sticky", cur_done, 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        sel        = 0;
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        abort      = 1'b0;
        s_data     = 32'h0;
        s_valid    = 1'b0;
        tail_rand  = 1'b1;
        tail_fixed = 4'h0;
        cl_cur     = 1024;
        div_cur    = 2;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // full load with a 50-cycle s_valid stall in the middle
        begin_op(1'b0, 0, 1024, 2);
        do_start(1'b0, 1'b0);
        drive_op(0, 60, 6000);
        chk_op_done((cl_cur * NC + WW - 1) / WW, par_m);
        chk_no_ready_after_done();

        // 10-flop chains, back-to-back strobes: two words, second mostly unused
        begin_op(1'b0, 1, 10, 1);
        do_start(1'b0, 1'b0);
        drive_op(0, -1, 500);
        chk_op_done((cl_cur * NC + WW - 1) / WW, par_m);
        chk_no_ready_after_done();

        // clear, only chain 0 tail high: even length gives parity 0
        tail_rand  = 1'b0;
        tail_fixed = 4'b0001;
        begin_op(1'b1, 0, 1024, 2);
        do_start(1'b1, 1'b0);
        drive_op(0, -1, 3000);
        chk_op_done(0, 1'(cl_cur % 2));

        // clear on odd length gives parity 1
        begin_op(1'b1, 2, 1023, 2);
        do_start(1'b0, 1'b0);
        drive_op(0, -1, 3000);
        chk_op_done(0, 1'(cl_cur % 2));

        // abort after 300 strobes, with a stray start during preset
        tail_rand = 1'b1;
        begin_op(1'b0, 0, 1024, 2);
        do_start(1'b1, 1'b1);
        drive_op(300, -1, 2000);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_iso", cur_iso, 0);
        chk("abort_cycle_done", cur_done, 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", cur_busy, 0);
        chk("abort_iso", cur_iso, 0);
        chk("abort_done", cur_done, 0);
        chk("abort_pReset", cur_preset, 0);
        chk("abort_shift_en", cur_en, 0);
        chk("abort_s_ready", cur_ready, 0);
        chk("abort_count_held", cur_cnt, op_strobes);
        chk("abort_parity_held", cur_par, par_m);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("iso_after_abort", cur_iso, 0);
        chk("done_after_abort", cur_done, 0);
        @(posedge clk);
        #1;

        // restart after abort, then reset in the middle of shifting
        begin_op(1'b0, 0, 1024, 2);
        do_start(1'b0, 1'b0);
        drive_op(20, -1, 500);
        chk("pre_reset_count", cur_cnt, 20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midshift_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
